// File: rtl/hazard_ctrl_unit.sv
// Hazard control for the ID stage of the five-stage pipeline.
// Detects load-use hazards (ID vs EX), taken branches resolved in EX and
// jumps decoded in ID, drives the PC / IF-ID enables and the ID flush
// controls, and keeps saturating stall/flush event counters for debug.
module hazard_ctrl_unit #(
    parameter int i_size       = 32,
    parameter int FLUSH_CYCLES = 1,   // 1..3 cycles of wrong-path flush per taken branch
    parameter int CNT_W        = 16
) (
    input  logic              clk,
    input  logic              rst,               // asynchronous, active low
    input  logic [i_size-1:0] id_Instruction,
    input  logic              ex_memread,
    input  logic [4:0]        ex_rt,
    input  logic              ex_branch_taken,
    output logic              pc_write,
    output logic              if_id_write,
    output logic              if_flush,
    output logic              ID_flush_lw_stall,
    output logic              ID_flush_branch,
    output logic [CNT_W-1:0]  stall_count,
    output logic [CNT_W-1:0]  flush_count
);

    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_LW    = 6'd1;
    localparam logic [5:0] OP_SW    = 6'd2;
    localparam logic [5:0] OP_BEQ   = 6'd3;
    localparam logic [5:0] OP_JUMP  = 6'd4;

    // The branch cycle itself is the first flush cycle, so the counter
    // covers only the extra cycles spent in BR_FLUSH.
    localparam logic [1:0] FCNT_LOAD   = 2'(FLUSH_CYCLES - 1);
    localparam bit         MULTI_FLUSH = (FLUSH_CYCLES > 1);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LW_STALL = 2'd1,
        BR_FLUSH = 2'd2
    } state_t;

    state_t           state_reg, state_next;
    logic [1:0]       fcnt_reg, fcnt_next;
    logic [CNT_W-1:0] stall_count_reg, flush_count_reg;
    logic             stall_inc, flush_inc;

    logic [5:0] id_opcode;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       uses_rs;
    logic       uses_rt;
    logic       id_jump;
    logic       lu_hit;
    logic       unused_instr_bits;

    assign id_opcode = id_Instruction[31:26];
    assign id_rs     = id_Instruction[25:21];
    assign id_rt     = id_Instruction[20:16];
    assign id_jump   = (id_opcode == OP_JUMP);

    // The immediate / function field plays no part in hazard detection.
    assign unused_instr_bits = ^id_Instruction[15:0];

    // Which register fields the ID instruction actually reads; lw only reads
    // rs (rt is its destination), jump and undefined opcodes read nothing.
    always_comb begin
        uses_rs = 1'b0;
        uses_rt = 1'b0;
        case (id_opcode)
            OP_RTYPE, OP_SW, OP_BEQ: begin
                uses_rs = 1'b1;
                uses_rt = 1'b1;
            end
            OP_LW:   uses_rs = 1'b1;
            default: ;
        endcase
    end

    // $zero is never a real dependency, so ex_rt == 0 never stalls.
    assign lu_hit = ex_memread && (ex_rt != 5'd0) &&
                    ((uses_rs && (ex_rt == id_rs)) || (uses_rt && (ex_rt == id_rt)));

    // Next-state and same-cycle output decode; priority branch > load-use > jump.
    always_comb begin
        state_next        = state_reg;
        fcnt_next         = fcnt_reg;
        pc_write          = 1'b1;
        if_id_write       = 1'b1;
        if_flush          = 1'b0;
        ID_flush_lw_stall = 1'b0;
        ID_flush_branch   = 1'b0;
        stall_inc         = 1'b0;
        flush_inc         = 1'b0;

        case (state_reg)
            RUN, LW_STALL: begin
                // LW_STALL is a single cycle: the bubble already sits in EX,
                // so the load-use check is not repeated there.
                state_next = RUN;
                if (ex_branch_taken) begin
                    if_flush        = 1'b1;
                    ID_flush_branch = 1'b1;
                    flush_inc       = 1'b1;
                    if (MULTI_FLUSH) begin
                        state_next = BR_FLUSH;
                        fcnt_next  = FCNT_LOAD;
                    end
                end else if ((state_reg == RUN) && lu_hit) begin
                    pc_write          = 1'b0;
                    if_id_write       = 1'b0;
                    ID_flush_lw_stall = 1'b1;
                    stall_inc         = 1'b1;
                    state_next        = LW_STALL;
                end else if (id_jump) begin
                    // The jump itself proceeds; only the fetched slot is squashed.
                    if_flush  = 1'b1;
                    flush_inc = 1'b1;
                end
            end
            BR_FLUSH: begin
                // Wrong-path window: everything is squashed, new branches are
                // absorbed without reloading the window or counting.
                if_flush        = 1'b1;
                ID_flush_branch = 1'b1;
                fcnt_next       = fcnt_reg - 2'd1;
                if (fcnt_reg <= 2'd1) begin
                    state_next = RUN;
                    fcnt_next  = 2'd0;
                end
            end
            default: begin
                state_next = RUN;
                fcnt_next  = 2'd0;
            end
        endcase

        // Hold the pipeline empty for as long as reset is asserted.
        if (!rst) begin
            pc_write          = 1'b0;
            if_id_write       = 1'b0;
            if_flush          = 1'b1;
            ID_flush_lw_stall = 1'b0;
            ID_flush_branch   = 1'b1;
            stall_inc         = 1'b0;
            flush_inc         = 1'b0;
        end
    end

    // FSM state and flush-window counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= RUN;
            fcnt_reg  <= 2'd0;
        end else begin
            state_reg <= state_next;
            fcnt_reg  <= fcnt_next;
        end
    end

    // Saturating performance counters; they stick at all-ones.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_count_reg <= '0;
            flush_count_reg <= '0;
        end else begin
            if (stall_inc && (stall_count_reg != CNT_MAX))
                stall_count_reg <= stall_count_reg + CNT_ONE;
            if (flush_inc && (flush_count_reg != CNT_MAX))
                flush_count_reg <= flush_count_reg + CNT_ONE;
        end
    end

    assign stall_count = stall_count_reg;
    assign flush_count = flush_count_reg;

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Directed bench for hazard_ctrl_unit. Two instances share the stimulus:
// u_dut3 (FLUSH_CYCLES=3, CNT_W=2) and u_dut1 (FLUSH_CYCLES=1, CNT_W=16).
// Output vectors below are {pc_write, if_id_write, if_flush,
// ID_flush_lw_stall, ID_flush_branch}.
module tb_hazard_ctrl_unit;

    logic        clk;
    logic        rst;
    logic [31:0] id_Instruction;
    logic        ex_memread;
    logic [4:0]  ex_rt;
    logic        ex_branch_taken;

    logic        pc_write3, if_id_write3, if_flush3, lw_stall3, br_flush3;
    logic [1:0]  stall_count3, flush_count3;
    logic        pc_write1, if_id_write1, if_flush1, lw_stall1, br_flush1;
    logic [15:0] stall_count1, flush_count1;

    int n_checks = 0;
    int n_pass   = 0;

    hazard_ctrl_unit #(.i_size(32), .FLUSH_CYCLES(3), .CNT_W(2)) u_dut3 (
        .clk               (clk),
        .rst               (rst),
        .id_Instruction    (id_Instruction),
        .ex_memread        (ex_memread),
        .ex_rt             (ex_rt),
        .ex_branch_taken   (ex_branch_taken),
        .pc_write          (pc_write3),
        .if_id_write       (if_id_write3),
        .if_flush          (if_flush3),
        .ID_flush_lw_stall (lw_stall3),
        .ID_flush_branch   (br_flush3),
        .stall_count       (stall_count3),
        .flush_count       (flush_count3)
    );

    hazard_ctrl_unit #(.i_size(32), .FLUSH_CYCLES(1), .CNT_W(16)) u_dut1 (
        .clk               (clk),
        .rst               (rst),
        .id_Instruction    (id_Instruction),
        .ex_memread        (ex_memread),
        .ex_rt             (ex_rt),
        .ex_branch_taken   (ex_branch_taken),
        .pc_write          (pc_write1),
        .if_id_write       (if_id_write1),
        .if_flush          (if_flush1),
        .ID_flush_lw_stall (lw_stall1),
        .ID_flush_branch   (br_flush1),
        .stall_count       (stall_count1),
        .flush_count       (flush_count1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt);
        return {op, rs, rt, 16'h0};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [4:0] outs3();
        return {pc_write3, if_id_write3, if_flush3, lw_stall3, br_flush3};
    endfunction

    function automatic logic [4:0] outs1();
        return {pc_write1, if_id_write1, if_flush1, lw_stall1, br_flush1};
    endfunction

    // One clock: drive on the falling edge, check the combinational outputs
    // mid-cycle, then check the counters just after the rising edge.
    task automatic cyc(input string tag, input logic [31:0] instr, input logic mr,
                       input logic [4:0] rt, input logic br,
                       input logic [4:0] e3, input logic [4:0] e1,
                       input int es3, input int ef3, input int es1, input int ef1);
        @(negedge clk);
        id_Instruction  = instr;
        ex_memread      = mr;
        ex_rt           = rt;
        ex_branch_taken = br;
        #1;
        check({tag, ".out3"}, 32'(outs3()), 32'(e3));
        check({tag, ".out1"}, 32'(outs1()), 32'(e1));
        @(posedge clk);
        #1;
        check({tag, ".stall3"}, 32'(stall_count3), 32'(es3));
        check({tag, ".flush3"}, 32'(flush_count3), 32'(ef3));
        check({tag, ".stall1"}, 32'(stall_count1), 32'(es1));
        check({tag, ".flush1"}, 32'(flush_count1), 32'(ef1));
        $display("cycle %s: out3=%05b out1=%05b s3=%0d f3=%0d s1=%0d f1=%0d",
                 tag, outs3(), outs1(), stall_count3, flush_count3, stall_count1, flush_count1);
    endtask

    localparam logic [5:0] RT = 6'd0, LW = 6'd1, BQ = 6'd3, JP = 6'd4;
    localparam logic [4:0] O_RUN = 5'b11000, O_LU = 5'b00010, O_BR = 5'b11101,
                           O_JMP = 5'b11100, O_RST = 5'b00101;

    initial begin
        rst             = 1'b0;
        id_Instruction  = 32'h0;
        ex_memread      = 1'b0;
        ex_rt           = 5'd0;
        ex_branch_taken = 1'b0;
        #2;
        check("rst.out3", 32'(outs3()), 32'(O_RST));
        check("rst.out1", 32'(outs1()), 32'(O_RST));
        check("rst.stall3", 32'(stall_count3), 32'd0);
        check("rst.flush1", 32'(flush_count1), 32'd0);
        @(posedge clk);
        #1 rst = 1'b1;

        // load-use then its single LW_STALL cycle
        cyc("lu",       mk(RT,5,0), 1, 5, 0, O_LU,  O_LU,  1,0,1,0);
        cyc("lw_stall", mk(RT,5,0), 1, 5, 0, O_RUN, O_RUN, 1,0,1,0);
        // no false stalls: $zero, and lw does not read rt
        cyc("zero_rt",  mk(RT,0,0), 1, 0, 0, O_RUN, O_RUN, 1,0,1,0);
        cyc("lw_rt",    mk(LW,3,7), 1, 7, 0, O_RUN, O_RUN, 1,0,1,0);
        cyc("beq_rt",   mk(BQ,1,7), 1, 7, 0, O_LU,  O_LU,  2,0,2,0);
        cyc("idle0",    mk(RT,0,0), 0, 0, 0, O_RUN, O_RUN, 2,0,2,0);
        // branch wins over load-use; 3-cycle window absorbs jumps
        cyc("br_lu",    mk(RT,5,0), 1, 5, 1, O_BR,  O_BR,  2,1,2,1);
        cyc("win_j2",   mk(JP,0,0), 0, 0, 0, O_BR,  O_JMP, 2,1,2,2);
        cyc("win_j3",   mk(JP,0,0), 0, 0, 0, O_BR,  O_JMP, 2,1,2,3);
        cyc("win_end",  mk(RT,0,0), 0, 0, 0, O_RUN, O_RUN, 2,1,2,3);
        // branch inside the window neither reloads nor counts
        cyc("br2",      mk(RT,0,0), 0, 0, 1, O_BR,  O_BR,  2,2,2,4);
        cyc("br2_in",   mk(RT,0,0), 0, 0, 1, O_BR,  O_BR,  2,2,2,5);
        cyc("br2_c3",   mk(RT,0,0), 0, 0, 0, O_BR,  O_RUN, 2,2,2,5);
        cyc("br2_end",  mk(RT,0,0), 0, 0, 0, O_RUN, O_RUN, 2,2,2,5);
        // jumps, flush counter saturates at 3 on the 2-bit instance
        cyc("jmp1",     mk(JP,0,0), 0, 0, 0, O_JMP, O_JMP, 2,3,2,6);
        cyc("jmp2",     mk(JP,0,0), 0, 0, 0, O_JMP, O_JMP, 2,3,2,7);
        cyc("lu2",      mk(RT,5,0), 1, 5, 0, O_LU,  O_LU,  3,3,3,7);

        // reset in LW_STALL acts immediately
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("mid_rst.out3", 32'(outs3()), 32'(O_RST));
        check("mid_rst.out1", 32'(outs1()), 32'(O_RST));
        check("mid_rst.stall3", 32'(stall_count3), 32'd0);
        check("mid_rst.flush3", 32'(flush_count3), 32'd0);
        check("mid_rst.stall1", 32'(stall_count1), 32'd0);
        check("mid_rst.flush1", 32'(flush_count1), 32'd0);
        $display("cycle mid_rst: out3=%05b out1=%05b", outs3(), outs1());
        @(posedge clk);
        #1 rst = 1'b1;

        // back in RUN: load-use detected again; 5+ stalls saturate at 3
        cyc("sat1",  mk(RT,5,0), 1, 5, 0, O_LU,  O_LU,  1,0,1,0);
        cyc("sat1s", mk(RT,5,0), 1, 5, 0, O_RUN, O_RUN, 1,0,1,0);
        cyc("sat2",  mk(RT,5,0), 1, 5, 0, O_LU,  O_LU,  2,0,2,0);
        cyc("sat2s", mk(RT,5,0), 1, 5, 0, O_RUN, O_RUN, 2,0,2,0);
        cyc("sat3",  mk(RT,5,0), 1, 5, 0, O_LU,  O_LU,  3,0,3,0);
        cyc("sat3s", mk(RT,5,0), 1, 5, 0, O_RUN, O_RUN, 3,0,3,0);
        cyc("sat4",  mk(RT,5,0), 1, 5, 0, O_LU,  O_LU,  3,0,4,0);
        cyc("sat4s", mk(RT,5,0), 1, 5, 0, O_RUN, O_RUN, 3,0,4,0);
        cyc("sat5",  mk(RT,5,0), 1, 5, 0, O_LU,  O_LU,  3,0,5,0);
        cyc("sat5s", mk(RT,5,0), 1, 5, 0, O_RUN, O_RUN, 3,0,5,0);
        // branch taken during LW_STALL opens a window
        cyc("lu6",   mk(RT,5,0), 1, 5, 0, O_LU,  O_LU,  3,0,6,0);
        cyc("ls_br", mk(RT,5,0), 1, 5, 1, O_BR,  O_BR,  3,1,6,1);
        cyc("ls_w2", mk(RT,0,0), 0, 0, 0, O_BR,  O_RUN, 3,1,6,1);
        cyc("ls_w3", mk(RT,0,0), 0, 0, 0, O_BR,  O_RUN, 3,1,6,1);
        cyc("ls_wx", mk(RT,0,0), 0, 0, 0, O_RUN, O_RUN, 3,1,6,1);
        // jump handled during LW_STALL
        cyc("lu7",   mk(RT,5,0), 1, 5, 0, O_LU,  O_LU,  3,1,7,1);
        cyc("ls_j",  mk(JP,0,0), 0, 0, 0, O_JMP, O_JMP, 3,2,7,2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl_unit.md
Name: hazard_ctrl_unit

Overview:
- Hazard detection block that drives the flush and stall inputs of the ID-stage control decoder (`ID_flush_lw_stall`, `ID_flush_branch`) plus the PC and IF/ID register enables.
- Detects load-use hazards between ID and EX, taken branches resolved in EX, and jumps decoded in ID.
- Sequences multi-cycle flush windows with a small FSM and keeps saturating stall/flush event counters for performance debug.

Parameters:
- i_size, 32, instruction width
- FLUSH_CYCLES, 1, cycles `ID_flush_branch`/`if_flush` stay asserted after a taken branch; legal range 1..3
- CNT_W, 16, width of the performance counters

Ports:
- clk  input  1  pipeline clock
- rst  input  1  asynchronous, active-low reset
- id_Instruction  input  i_size  instruction currently in ID
- ex_memread  input  1  EX-stage instruction is lw
- ex_rt  input  5  destination register of the EX-stage instruction
- ex_branch_taken  input  1  beq in EX resolved taken (one-cycle pulse)
- pc_write  output  1  PC update enable
- if_id_write  output  1  IF/ID register write enable
- if_flush  output  1  clear IF/ID to NOP
- ID_flush_lw_stall  output  1  force ID control signals to zero (bubble)
- ID_flush_branch  output  1  force ID control signals to zero (wrong path)
- stall_count  output  CNT_W  number of load-use stalls taken, saturating
- flush_count  output  CNT_W  number of branch plus jump flush events, saturating

Behaviour:
- Opcode map `id_Instruction[31:26]`: 0 rtype, 1 lw, 2 sw, 3 beq, 4 jump. Fields: `id_rs = [25:21]`, `id_rt = [20:16]`.
- Sources: rtype/sw/beq use rs and rt; lw uses rs only; jump and undefined opcodes use none.
- Load-use condition (lu):
  - `ex_memread=1`, `ex_rt!=0`, and `ex_rt` equals a source register of the ID instruction.
  - Evaluated only in state RUN.
- FSM states: RUN, LW_STALL, BR_FLUSH. A 2-bit down-counter `fcnt` is used in BR_FLUSH.
- Priority when events coincide: `ex_branch_taken` > lu > jump.
- RUN:
  - `ex_branch_taken=1`: `if_flush=1`, `ID_flush_branch=1`, `pc_write=1` (branch target loads). `flush_count+1`. If FLUSH_CYCLES>1, go to BR_FLUSH with `fcnt=FLUSH_CYCLES-1`, else stay in RUN.
  - lu: `ID_flush_lw_stall=1`, `pc_write=0`, `if_id_write=0`. `stall_count+1`. Go to LW_STALL.
  - jump in ID (no branch, no lu): `if_flush=1`, `pc_write=1`, `if_id_write=1`, `ID_flush_branch=0` (the jump itself proceeds). `flush_count+1`. Stay in RUN.
  - Otherwise: `pc_write=1`, `if_id_write=1`, all flush outputs 0.
- LW_STALL: lasts exactly one cycle. Outputs as the RUN default, with no lu re-detection (the bubble is now in EX).
  - Jump in ID is handled this cycle, as in RUN.
  - `ex_branch_taken` here has the same effect as in RUN (flush, count, possible BR_FLUSH).
  - Next state is RUN unless the branch path moves to BR_FLUSH.
- BR_FLUSH:
  - `if_flush=1`, `ID_flush_branch=1`, `pc_write=1`, `if_id_write=1`.
  - lu and jump are ignored.
  - `fcnt` decrements; go to RUN when `fcnt` reaches 1 in this cycle.
  - A new `ex_branch_taken` here does not reload `fcnt` and is not counted.
- Output timing: all outputs except the counters are combinational from state and inputs within the same cycle. Counters update on the rising clk edge.
- Counters saturate at all-ones and never wrap.
- Reset:
  - `rst=0` asynchronously forces state RUN, `fcnt=0`, `stall_count=0`, `flush_count=0`.
  - While in reset: `pc_write=0`, `if_id_write=0`, `if_flush=1`, `ID_flush_lw_stall=0`, `ID_flush_branch=1` (pipeline held empty).
  - Reset asserted mid-stall or mid-flush aborts the sequence immediately. After release, the FSM is in RUN.

Test Plan:
- Load-use: EX lw `ex_rt=5`, ID rtype `rs=5` -> one cycle with `ID_flush_lw_stall=1`, `pc_write=0`, `if_id_write=0`; next cycle LW_STALL with all enables 1; `stall_count` 0->1.
- No false stall: EX lw `ex_rt=0` with ID `rs=0`; and EX lw `ex_rt=7` with ID lw `rt=7` (lw does not read rt) -> no stall, `stall_count` stays 0.
- Branch vs load-use same cycle: `ex_branch_taken=1` plus lu condition -> `ID_flush_branch=1`, `if_flush=1`, `ID_flush_lw_stall=0`; `flush_count=1`, `stall_count=0`.
- FLUSH_CYCLES=3: taken branch -> `ID_flush_branch` high for exactly 3 cycles; a jump in ID during cycles 2-3 causes no extra count; `flush_count=1`.
- Jump: ID opcode 4 -> `if_flush=1` for 1 cycle, `ID_flush_branch=0`, `pc_write=1`; `flush_count+1`.
- Reset and saturation: assert `rst=0` in LW_STALL -> immediate RUN, counters 0, reset output values as specified. With CNT_W=2, 5 stalls -> `stall_count` holds at 3.
